// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller.
// Sits between the CPU load/store port and a single-beat data memory; line
// refills are sequenced word by word, stores always go straight to memory.
module dcache_ctrl #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned SETS        = 16,
  parameter int unsigned BLOCK_WORDS = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cpu_req_i,
  input  logic                  cpu_we_i,
  input  logic                  cpu_byte_i,
  input  logic                  cache_en_i,
  input  logic [DATA_WIDTH-1:0] cpu_addr_i,
  input  logic [DATA_WIDTH-1:0] cpu_wdata_i,
  output logic [DATA_WIDTH-1:0] cpu_rdata_o,
  output logic                  stall_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic                  mem_byte_o,
  output logic [DATA_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  input  logic                  mem_ready_i,
  output logic [31:0]           hit_cnt_o,
  output logic [31:0]           miss_cnt_o
);

  localparam int unsigned WordBits = $clog2(BLOCK_WORDS);
  localparam int unsigned IdxBits  = $clog2(SETS);
  localparam int unsigned TagBits  = DATA_WIDTH - IdxBits - WordBits - 2;
  localparam int unsigned Lines    = SETS * BLOCK_WORDS;
  localparam logic [WordBits-1:0] LastWord = WordBits'(BLOCK_WORDS - 1);

  typedef enum logic [1:0] {
    StIdle,
    StRefill,
    StWrite,
    StUncached
  } state_e;

  state_e state_q, state_d;

  logic [SETS-1:0]       valid_q;
  logic [TagBits-1:0]    tag_q  [SETS];
  logic [DATA_WIDTH-1:0] data_q [Lines];

  // Refill target is latched so the fill finishes even if the CPU request drops.
  logic [WordBits-1:0] cnt_q;
  logic [TagBits-1:0]  fill_tag_q;
  logic [IdxBits-1:0]  fill_idx_q;

  logic [31:0] hit_cnt_q, miss_cnt_q;

  logic [1:0]            addr_byte;
  logic [WordBits-1:0]   addr_word;
  logic [IdxBits-1:0]    addr_idx;
  logic [TagBits-1:0]    addr_tag;
  logic                  hit;
  logic [DATA_WIDTH-1:0] hit_word;
  logic [DATA_WIDTH-1:0] store_word;

  logic hit_load, miss_start, fill_beat, fill_last, store_upd;

  assign addr_byte = cpu_addr_i[1:0];
  assign addr_word = cpu_addr_i[2 +: WordBits];
  assign addr_idx  = cpu_addr_i[2 + WordBits +: IdxBits];
  assign addr_tag  = cpu_addr_i[DATA_WIDTH-1 -: TagBits];

  assign hit      = valid_q[addr_idx] && (tag_q[addr_idx] == addr_tag);
  assign hit_word = data_q[{addr_idx, addr_word}];

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;

  // Byte loads return the addressed lane zero-extended; word loads pass through.
  function automatic logic [DATA_WIDTH-1:0] load_sel(input logic [DATA_WIDTH-1:0] word,
                                                     input logic                  is_byte,
                                                     input logic [1:0]            lane);
    logic [7:0] b;
    b = word[{lane, 3'b000} +: 8];
    return is_byte ? DATA_WIDTH'(b) : word;
  endfunction

  // Cached copy of a store that hits: merge a single lane or replace the word.
  always_comb begin
    store_word = hit_word;
    if (cpu_byte_i) begin
      store_word[{addr_byte, 3'b000} +: 8] = cpu_wdata_i[7:0];
    end else begin
      store_word = cpu_wdata_i;
    end
  end

  // Next-state, memory handshake outputs and datapath strobes.
  always_comb begin
    state_d     = state_q;
    stall_o     = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_byte_o  = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    cpu_rdata_o = '0;
    hit_load    = 1'b0;
    miss_start  = 1'b0;
    fill_beat   = 1'b0;
    fill_last   = 1'b0;
    store_upd   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (cpu_req_i) begin
          if (cpu_we_i) begin
            stall_o = 1'b1;
            state_d = StWrite;
          end else if (!cache_en_i) begin
            stall_o = 1'b1;
            state_d = StUncached;
          end else if (hit) begin
            cpu_rdata_o = load_sel(hit_word, cpu_byte_i, addr_byte);
            hit_load    = 1'b1;
          end else begin
            stall_o    = 1'b1;
            miss_start = 1'b1;
            state_d    = StRefill;
          end
        end
      end

      StRefill: begin
        stall_o    = 1'b1;
        mem_req_o  = 1'b1;
        mem_addr_o = {fill_tag_q, fill_idx_q, cnt_q, 2'b00};
        if (mem_ready_i) begin
          fill_beat = 1'b1;
          if (cnt_q == LastWord) begin
            fill_last = 1'b1;
            state_d   = StIdle;
          end
        end
      end

      StWrite: begin
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_byte_o  = cpu_byte_i;
        mem_addr_o  = cpu_addr_i;
        mem_wdata_o = cpu_wdata_i;
        stall_o     = !mem_ready_i;
        if (mem_ready_i) begin
          store_upd = cache_en_i && hit;
          state_d   = StIdle;
        end
      end

      StUncached: begin
        mem_req_o  = 1'b1;
        mem_addr_o = {cpu_addr_i[DATA_WIDTH-1:2], 2'b00};
        stall_o    = !mem_ready_i;
        if (mem_ready_i) begin
          cpu_rdata_o = load_sel(mem_rdata_i, cpu_byte_i, addr_byte);
          state_d     = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase

    // While reset is held every output reads as idle, even with a CPU request present.
    if (!rst_i) begin
      state_d     = StIdle;
      stall_o     = 1'b0;
      mem_req_o   = 1'b0;
      mem_we_o    = 1'b0;
      mem_byte_o  = 1'b0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      cpu_rdata_o = '0;
      hit_load    = 1'b0;
      miss_start  = 1'b0;
      fill_beat   = 1'b0;
      fill_last   = 1'b0;
      store_upd   = 1'b0;
    end
  end

  // Control state: FSM, valid bits, refill sequencing and statistics counters.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= StIdle;
      valid_q    <= '0;
      cnt_q      <= '0;
      fill_tag_q <= '0;
      fill_idx_q <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (miss_start) begin
        cnt_q      <= '0;
        fill_tag_q <= addr_tag;
        fill_idx_q <= addr_idx;
      end else if (fill_beat) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (fill_last) begin
        valid_q[fill_idx_q] <= 1'b1;
      end
      if (hit_load) begin
        hit_cnt_q <= hit_cnt_q + 32'd1;
      end
      if (miss_start) begin
        miss_cnt_q <= miss_cnt_q + 32'd1;
      end
    end
  end

  // Tag and data arrays carry no reset; valid_q alone qualifies their contents.
  always_ff @(posedge clk_i) begin
    if (fill_beat) begin
      data_q[{fill_idx_q, cnt_q}] <= mem_rdata_i;
    end
    if (fill_last) begin
      tag_q[fill_idx_q] <= fill_tag_q;
    end
    if (store_upd) begin
      data_q[{addr_idx, addr_word}] <= store_word;
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Bench for dcache_ctrl: directed scenarios followed by random load/store
// traffic, checked against a set/tag/word cache model and a sparse memory.
module tb_dcache_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req_i, cpu_we_i, cpu_byte_i, cache_en_i;
  logic [31:0] cpu_addr_i, cpu_wdata_i, cpu_rdata_o;
  logic        stall_o, mem_req_o, mem_we_o, mem_byte_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic        mem_ready_i;
  logic [31:0] hit_cnt_o, miss_cnt_o;

  always #5 clk = ~clk;

  dcache_ctrl dut (
    .clk_i      (clk),
    .rst_i      (rst_n),
    .cpu_req_i  (cpu_req_i),
    .cpu_we_i   (cpu_we_i),
    .cpu_byte_i (cpu_byte_i),
    .cache_en_i (cache_en_i),
    .cpu_addr_i (cpu_addr_i),
    .cpu_wdata_i(cpu_wdata_i),
    .cpu_rdata_o(cpu_rdata_o),
    .stall_o    (stall_o),
    .mem_req_o  (mem_req_o),
    .mem_we_o   (mem_we_o),
    .mem_byte_o (mem_byte_o),
    .mem_addr_o (mem_addr_o),
    .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i),
    .mem_ready_i(mem_ready_i),
    .hit_cnt_o  (hit_cnt_o),
    .miss_cnt_o (miss_cnt_o)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // ---------------- memory environment ----------------
  logic [31:0] mem [int unsigned];

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    int unsigned w;
    w = a >> 2;
    if (mem.exists(w)) return mem[w];
    return 32'h1000 + w;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] a,
                                        input logic [31:0] wd, input logic bt);
    logic [31:0] r;
    if (!bt) return wd;
    r = old;
    r[{a[1:0], 3'b000} +: 8] = wd[7:0];
    return r;
  endfunction

  function automatic logic [31:0] lsel(input logic [31:0] w, input logic bt, input logic [31:0] a);
    logic [7:0] b;
    b = w[{a[1:0], 3'b000} +: 8];
    return bt ? {24'h0, b} : w;
  endfunction

  typedef struct {
    logic        we;
    logic        bt;
    logic [31:0] addr;
    logic [31:0] wd;
  } beat_t;

  beat_t log_q[$];

  // Memory responder: records completed beats at the rising edge, drives
  // ready/data at the falling edge after a random 0..3 cycle wait per beat.
  initial begin
    int    lat;
    int    target;
    bit    done;
    beat_t b;
    mem_ready_i = 1'b0;
    mem_rdata_i = '0;
    lat    = 0;
    target = $urandom_range(0, 3);
    forever begin
      @(posedge clk);
      done = rst_n && mem_req_o && mem_ready_i;
      if (done) begin
        b.we   = mem_we_o;
        b.bt   = mem_byte_o;
        b.addr = mem_addr_o;
        b.wd   = mem_wdata_o;
        log_q.push_back(b);
        if (b.we) mem[b.addr >> 2] = merge(mem_rd(b.addr), b.addr, b.wd, b.bt);
      end
      @(negedge clk);
      if (done) begin
        lat    = 0;
        target = $urandom_range(0, 3);
      end
      if (!rst_n || !mem_req_o) begin
        mem_ready_i = 1'b0;
        lat         = 0;
      end else if (lat >= target) begin
        mem_ready_i = 1'b1;
        mem_rdata_i = mem_rd(mem_addr_o);
      end else begin
        mem_ready_i = 1'b0;
        lat++;
      end
    end
  end

  // ---------------- cache reference model ----------------
  bit          mvalid [16];
  logic [23:0] mtag   [16];
  logic [31:0] mdata  [64];
  logic [31:0] mhit, mmiss;

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mvalid[i] = 1'b0;
    mhit  = 0;
    mmiss = 0;
  endtask

  // One CPU access: predicts memory traffic, load data and counters, then drives
  // the request and holds it until stall_o drops.
  task automatic do_op(input logic we, input logic bt, input logic en,
                       input logic [31:0] addr, input logic [31:0] wd,
                       output logic [31:0] rd);
    beat_t       exp_q[$];
    beat_t       e;
    logic [31:0] exp_rd;
    logic [31:0] la;
    int          set, wrd, cyc, n;
    bit          hit;
    set    = int'(addr[7:4]);
    wrd    = int'(addr[3:2]);
    hit    = mvalid[set] && (mtag[set] == addr[31:8]);
    exp_rd = '0;
    if (we) begin
      e = '{we: 1'b1, bt: bt, addr: addr, wd: wd};
      exp_q.push_back(e);
      if (en && hit) mdata[set*4+wrd] = merge(mdata[set*4+wrd], addr, wd, bt);
    end else if (!en) begin
      e = '{we: 1'b0, bt: 1'b0, addr: {addr[31:2], 2'b00}, wd: 32'h0};
      exp_q.push_back(e);
      exp_rd = lsel(mem_rd(addr), bt, addr);
    end else begin
      if (!hit) begin
        for (int k = 0; k < 4; k++) begin
          la = {addr[31:4], 4'(k * 4)};
          e  = '{we: 1'b0, bt: 1'b0, addr: la, wd: 32'h0};
          exp_q.push_back(e);
          mdata[set*4+k] = mem_rd(la);
        end
        mvalid[set] = 1'b1;
        mtag[set]   = addr[31:8];
        mmiss++;
      end
      mhit++;
      exp_rd = lsel(mdata[set*4+wrd], bt, addr);
    end

    log_q.delete();
    cpu_req_i   = 1'b1;
    cpu_we_i    = we;
    cpu_byte_i  = bt;
    cache_en_i  = en;
    cpu_addr_i  = addr;
    cpu_wdata_i = wd;
    #1;
    cyc = 0;
    while (stall_o && cyc < 100) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    check("op_completes", 32'(stall_o), 32'h0);
    rd = cpu_rdata_o;
    if (!we) check("load_rdata", rd, exp_rd);
    if (!we && en && hit) check("hit_no_stall", 32'(cyc), 32'h0);
    @(posedge clk);
    @(negedge clk);
    cpu_req_i = 1'b0;

    check("beat_count", 32'(log_q.size()), 32'(exp_q.size()));
    n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check("beat_addr", log_q[i].addr, exp_q[i].addr);
      check("beat_we", 32'(log_q[i].we), 32'(exp_q[i].we));
      if (exp_q[i].we) begin
        check("beat_byte", 32'(log_q[i].bt), 32'(exp_q[i].bt));
        check("beat_wdata", log_q[i].wd, exp_q[i].wd);
      end
    end
    check("hit_cnt", hit_cnt_o, mhit);
    check("miss_cnt", miss_cnt_o, mmiss);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic [31:0] a;
    logic        we, bt, en;

    rst_n       = 1'b0;
    cpu_req_i   = 1'b0;
    cpu_we_i    = 1'b0;
    cpu_byte_i  = 1'b0;
    cache_en_i  = 1'b1;
    cpu_addr_i  = '0;
    cpu_wdata_i = '0;
    model_reset();

    #1;
    check("rst_stall", 32'(stall_o), 32'h0);
    check("rst_mem_req", 32'(mem_req_o), 32'h0);
    check("rst_mem_we", 32'(mem_we_o), 32'h0);
    check("rst_mem_byte", 32'(mem_byte_o), 32'h0);
    check("rst_mem_addr", mem_addr_o, 32'h0);
    check("rst_mem_wdata", mem_wdata_o, 32'h0);
    check("rst_rdata", cpu_rdata_o, 32'h0);
    check("rst_hit_cnt", hit_cnt_o, 32'h0);
    check("rst_miss_cnt", miss_cnt_o, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Cold miss, then a hit in the same line.
    do_op(1'b0, 1'b0, 1'b1, 32'h104, 32'h0, rd);
    check("plan_lw_104", rd, 32'h1041);
    check("plan_miss_1", miss_cnt_o, 32'd1);
    check("plan_hit_1", hit_cnt_o, 32'd1);
    do_op(1'b0, 1'b0, 1'b1, 32'h108, 32'h0, rd);
    check("plan_lw_108", rd, 32'h1042);
    check("plan_hit_2", hit_cnt_o, 32'd2);

    // Byte store hit updates both memory and the cached line.
    do_op(1'b1, 1'b1, 1'b1, 32'h105, 32'h0000_00AB, rd);
    do_op(1'b0, 1'b1, 1'b1, 32'h105, 32'h0, rd);
    check("plan_lbu_105", rd, 32'h0000_00AB);
    do_op(1'b0, 1'b0, 1'b1, 32'h104, 32'h0, rd);
    check("plan_lw_104_merged", rd, 32'h0000_AB41);

    // Store miss does not allocate; the following load refills.
    do_op(1'b1, 1'b0, 1'b1, 32'h2000, 32'hDEAD_BEEF, rd);
    do_op(1'b0, 1'b0, 1'b1, 32'h2000, 32'h0, rd);
    check("plan_lw_2000", rd, 32'hDEAD_BEEF);

    // Conflict in set 0 evicts, and the old line misses again.
    do_op(1'b0, 1'b0, 1'b1, 32'h1104, 32'h0, rd);
    check("plan_lw_1104", rd, 32'h1441);
    do_op(1'b0, 1'b0, 1'b1, 32'h104, 32'h0, rd);
    check("plan_lw_104_again", rd, 32'h0000_AB41);

    // Uncached load bypasses the cache.
    do_op(1'b0, 1'b0, 1'b0, 32'h104, 32'h0, rd);
    check("plan_uncached", rd, 32'h0000_AB41);

    // Reset in the middle of a refill.
    cpu_req_i  = 1'b1;
    cpu_we_i   = 1'b0;
    cpu_byte_i = 1'b0;
    cache_en_i = 1'b1;
    cpu_addr_i = 32'h3104;
    repeat (3) @(negedge clk);
    #1;
    check("midrst_req_before", 32'(mem_req_o), 32'h1);
    rst_n = 1'b0;
    #1;
    check("midrst_req", 32'(mem_req_o), 32'h0);
    check("midrst_stall", 32'(stall_o), 32'h0);
    cpu_req_i = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    check("midrst_hit_cnt", hit_cnt_o, 32'h0);
    check("midrst_miss_cnt", miss_cnt_o, 32'h0);
    @(negedge clk);
    do_op(1'b0, 1'b0, 1'b1, 32'h104, 32'h0, rd);
    check("post_rst_miss", miss_cnt_o, 32'd1);

    // Random traffic over a few tags so hits, conflicts and stale lines all occur.
    for (int i = 0; i < 300; i++) begin
      we = ($urandom_range(0, 2) == 0);
      bt = $urandom_range(0, 1) == 1;
      en = ($urandom_range(0, 7) != 0);
      a  = {22'h0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
            2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      if (!bt) a[1:0] = 2'b00;
      do_op(we, bt, en, a, $urandom, rd);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
- Direct-mapped, write-through, no-write-allocate data cache controller between the CPU load/store port (ALU address, register write data, byte-op flag, cache-enable flag) and the data memory.
- Holds tag/valid/data arrays and sequences line refills and write-through stores.
- Stalls the CPU (pc and register-file write enable) while a memory transaction is outstanding.

Parameters:
- DATA_WIDTH, 32, address/data width.
- SETS, 16, number of lines (power of 2).
- BLOCK_WORDS, 4, words per line (power of 2, ≥2).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- cpu_req_i  in  1  load/store valid this cycle.
- cpu_we_i  in  1  1 = store, 0 = load.
- cpu_byte_i  in  1  byte access (lbu/sb) vs word access.
- cache_en_i  in  1  0 = uncached bypass.
- cpu_addr_i  in  DATA_WIDTH  byte address.
- cpu_wdata_i  in  DATA_WIDTH  store data.
- cpu_rdata_o  out  DATA_WIDTH  load data.
- stall_o  out  1  CPU must hold state and inputs.
- mem_req_o  out  1  memory request.
- mem_we_o  out  1  memory write.
- mem_byte_o  out  1  memory byte write.
- mem_addr_o  out  DATA_WIDTH  memory byte address.
- mem_wdata_o  out  DATA_WIDTH  memory write data.
- mem_rdata_i  in  DATA_WIDTH  memory read data, valid with mem_ready_i.
- mem_ready_i  in  1  beat complete.
- hit_cnt_o  out  32  load hits.
- miss_cnt_o  out  32  load misses.

Behaviour:
- Address split: [1:0] byte, next log2(BLOCK_WORDS) bits word offset, next log2(SETS) bits index, rest tag. Defaults: [3:2] word, [7:4] index, [31:8] tag.
- States: IDLE, REFILL, WRITE, UNCACHED.
- Reset (rst_i low, async):
  - state IDLE, all valid bits 0, beat counter 0, counters 0.
  - mem_req_o, mem_we_o, mem_byte_o, stall_o = 0; mem_addr_o, mem_wdata_o, cpu_rdata_o = 0.
  - Data/tag arrays are not reset.
- IDLE, cpu_req_i = 0: stall_o = 0, no action.
- IDLE, load, cache_en_i = 1, valid & tag match (hit):
  - cpu_rdata_o = selected word, combinational; stall_o = 0; hit_cnt_o += 1 at edge.
  - Byte load returns byte at offset [1:0], zero-extended.
- IDLE, load miss:
  - stall_o = 1 combinationally; beat counter = 0; miss_cnt_o += 1; next state REFILL.
- REFILL:
  - stall_o = 1, mem_req_o = 1, mem_we_o = 0, mem_addr_o = {tag, index, counter, 00}.
  - Each cycle with mem_ready_i: write mem_rdata_i into line word[counter], counter += 1.
  - On last beat: set valid and tag, go IDLE.
  - The held load then hits in IDLE, so hit_cnt_o also increments for that load.
  - Miss latency = 1 + sum of beat latencies + 1 cycles.
- IDLE, store (any cache_en_i): stall_o = 1, next state WRITE.
- WRITE:
  - mem_req_o = 1, mem_we_o = 1, mem_byte_o = cpu_byte_i, mem_addr_o = cpu_addr_i, mem_wdata_o = cpu_wdata_i.
  - stall_o = !mem_ready_i, so the CPU advances on the ready edge.
  - On ready: if cache_en_i and hit, update the cached word (byte store writes lane [1:0] with wdata[7:0]); go IDLE.
  - Store miss never allocates.
- IDLE, load, cache_en_i = 0:
  - stall_o = 1, go UNCACHED. No counter change.
- UNCACHED:
  - Single read of the word address; cpu_rdata_o = mem_rdata_i (byte-selected) and stall_o = 0 in the cycle mem_ready_i is high; go IDLE.
- Memory handshake:
  - Once asserted, mem_req_o, address, data and we hold stable until mem_ready_i. No abort.
  - mem_ready_i outside a request is ignored.
- CPU inputs must be stable while stall_o = 1. A refill completes even if cpu_req_i drops.
- Conflict miss overwrites the line; no writeback is needed (write-through).
- Counters wrap at 2^32.
- Reset mid-transaction aborts immediately to reset values. The memory side must tolerate the dropped request.

Test Plan:
- Reset, load word 0x0000_0104 with memory word i = 0x1000+i and ready 2 cycles after each request beat → 4 beats at 0x100/104/108/10C, stall high until line filled, rdata = 0x1041, miss_cnt = 1, hit_cnt = 1.
- Load 0x108 next → stall 0, rdata = 0x1042 same cycle, no mem_req, hit_cnt = 2.
- sb 0xAB to 0x105 (hit) → one memory write, byte = 1, addr 0x105; then lbu 0x105 → 0xAB with no refill, and lw 0x104 → 0x0000_AB41.
- sw to 0x2000 (miss), then lw 0x2000 → write issued without allocation, then a refill miss (miss_cnt increments).
- Load 0x1104 (same index 0, different tag) after line 0x100 cached → refill from 0x1100; subsequent 0x104 misses again.
- cache_en_i = 0, lw 0x104 → single memory read, rdata = memory value, counters unchanged. Then assert rst_i low mid-REFILL → mem_req_o and stall_o drop immediately; after release, lw 0x104 misses (valid cleared).
